matrix_result_serializer: RTL and testbench
===========================================

# matrix_result_serializer

Reads a completed N×N result matrix from the multiplier's concatenated output bus and streams it out one element per transfer, in row-major order, over a valid/ready handshake. It sits downstream of the matrix multiplier. It converts the wide parallel result into a narrow element stream for a host interface, UART bridge or memory writer. A row/column counter FSM drives the stream, and the block snapshots the matrix so the multiplier may start its next operation immediately.

## Interface
- DATA_W, 8, width of one matrix element
- N, 3, matrix dimension (N×N elements); N ≤ 4 so row/col indices fit 2 bits
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- load  input  1  capture request; honoured only in IDLE
- concatinated_matrix  input  N*N*DATA_W  result matrix; element (r,c) at bits [DATA_W*(N*r+c) +: DATA_W]
- out_valid  output  1  out_data/out_row/out_col/out_last hold a valid element
- out_ready  input  1  consumer accepts the element this cycle
- out_data  output  DATA_W  current element value
- out_row  output  2  row index of current element
- out_col  output  2  column index of current element
- out_last  output  1  current element is (N-1,N-1)
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse after final transfer

## Operation
- States: IDLE, SEND, DONE. Reset forces IDLE, clears the snapshot register, sets row=col=0 and drives every output to 0.
- IDLE: if load=1, snapshot concatinated_matrix, set row=col=0, go to SEND. Otherwise hold.
- SEND: out_valid=1. out_data = snapshot element (row,col). out_last = (row==N-1 && col==N-1).
- Transfer = out_valid && out_ready. On a transfer:
  - If col<N-1, col++.
  - Else col←0 and row++.
  - If the transfer carries out_last, go to DONE, with row and col returning to 0.
- Without a transfer, out_data, out_row, out_col and out_last hold stable. Stall length is unbounded.
- DONE: done=1 and out_valid=0 for exactly one cycle, then IDLE.
- load is ignored in SEND and DONE. Changes on concatinated_matrix after capture have no effect on the stream.
- out_ready while out_valid=0 has no effect.
- An async reset asserted mid-stream aborts immediately. Outputs go to 0, no done pulse is produced, and the next load starts from element (0,0).
- No arithmetic is performed. Data passes through bit-exact.

## Timing
- Load accepted on edge t → out_valid=1 with element (0,0) from cycle t+1. Output is registered, so there is no combinational path from load to outputs.
- out_ready is combinationally sampled only for the transfer decision. No output depends combinationally on out_ready.
- With out_ready held high: N*N transfers on consecutive cycles t+1 … t+N*N, done in cycle t+N*N+1, IDLE at t+N*N+2. Earliest next load is accepted on that cycle's edge.
- Each stall cycle extends the sequence by exactly one cycle.
- busy is high from t+1 through the DONE cycle inclusive.

## Test plan
- Reset state: hold rst=0 with out_ready=1 and load pulsing → out_valid, busy, done, out_data, out_row, out_col and out_last all 0. Release rst, then 3 idle cycles → still 0.
- Full stream, N=3: concatinated_matrix=72'h090807060504030201, pulse load, out_ready=1 → nine transfers of 01…09 on consecutive cycles, (row,col) going (0,0),(0,1),(0,2),(1,0)…(2,2), out_last only on 09. done pulses the cycle after 09, busy drops the following cycle.
- Backpressure: same matrix, out_ready toggled 1,0,0,1,… → each element is held stable while ready=0, no element is skipped or repeated, and total duration is 9 + number of stall cycles + 1.
- Snapshot isolation: after load, change concatinated_matrix to all FF and pulse load again during SEND → stream still outputs 01…09, and the second load is not captured.
- Mid-stream reset: assert rst=0 after the third transfer (03), then release → outputs 0 and no done pulse. A new load of 72'h111…11 streams nine 0x11 values starting at (0,0).
- Back-to-back: a second load issued on the first IDLE cycle after done → out_valid is back high the next cycle with the new (0,0) element.

Source files
------------

// File: rtl/matrix_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_result_serializer
// Description : Captures a completed N x N result matrix from the multiplier's
//               concatenated output bus and streams it out one element per
//               valid/ready transfer, in row-major order. The matrix is
//               snapshotted on load, so the multiplier is free to start its
//               next operation immediately.
//
// Ports
//   clk                 : single clock, all state on rising edge
//   rst                 : asynchronous reset, active-low
//   load                : capture request, honoured only while idle
//   concatinated_matrix : element (r,c) at [DATA_W*(N*r+c) +: DATA_W]
//   out_valid           : out_data/out_row/out_col/out_last hold an element
//   out_ready           : consumer accepts the current element this cycle
//   out_data            : current element value
//   out_row / out_col   : row / column index of the current element
//   out_last            : current element is (N-1,N-1)
//   busy                : high whenever the block is not idle
//   done                : one-cycle pulse after the final transfer
//
// Revision    : 1.0  initial release
// ============================================================================
module matrix_result_serializer #(
    parameter int DATA_W = 8,
    parameter int N      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [N*N*DATA_W-1:0]   concatinated_matrix,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [1:0]              out_row,
    output logic [1:0]              out_col,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int         c_IDX_W = (N * N > 1) ? $clog2(N * N) : 1;
    localparam logic [1:0] c_LAST  = 2'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                         r_state;
    logic [N*N-1:0][DATA_W-1:0]     r_snapshot;

    logic                           w_transfer;
    logic                           w_col_wrap;
    logic [1:0]                     w_next_row;
    logic [1:0]                     w_next_col;
    logic [c_IDX_W-1:0]             w_next_idx;
    logic                           w_next_last;

    // out_ready only steers the advance decision; every output is registered,
    // so nothing reaches the outputs combinationally from out_ready or load.
    assign w_transfer  = out_valid && out_ready;
    assign w_col_wrap  = (out_col == c_LAST);
    assign w_next_col  = w_col_wrap ? 2'd0 : out_col + 2'd1;
    assign w_next_row  = w_col_wrap ? out_row + 2'd1 : out_row;
    assign w_next_idx  = c_IDX_W'(N * int'(w_next_row) + int'(w_next_col));
    assign w_next_last = (w_next_row == c_LAST) && (w_next_col == c_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_snapshot <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= 2'd0;
            out_col    <= 2'd0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        // Element (0,0) is presented straight from the bus on
                        // the capture edge; later elements come from the
                        // snapshot.
                        r_snapshot <= concatinated_matrix;
                        out_data   <= concatinated_matrix[DATA_W-1:0];
                        out_row    <= 2'd0;
                        out_col    <= 2'd0;
                        out_last   <= (N == 1);
                        out_valid  <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (w_transfer) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_row   <= 2'd0;
                            out_col   <= 2'd0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            out_row  <= w_next_row;
                            out_col  <= w_next_col;
                            out_data <= r_snapshot[w_next_idx];
                            out_last <= w_next_last;
                        end
                    end
                end

                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_result_serializer
// Description : Self-checking bench for matrix_result_serializer. Expected
//               elements are derived from the matrix value by shifting and
//               row/col from the element index by division/modulo.
// Revision    : 1.0  initial release
// ============================================================================
module tb_matrix_result_serializer;

    localparam int DATA_W = 8;
    localparam int N      = 3;
    localparam int NE     = N * N;
    localparam int MAXCYC = 300;

    logic              clk;
    logic              rst;
    logic              load;
    logic [NE*DATA_W-1:0] concatinated_matrix;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              out_last;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    matrix_result_serializer #(
        .DATA_W (DATA_W),
        .N      (N)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .load                (load),
        .concatinated_matrix (concatinated_matrix),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_row             (out_row),
        .out_col             (out_col),
        .out_last            (out_last),
        .busy                (busy),
        .done                (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: element idx of a row-major matrix
    function automatic logic [DATA_W-1:0] ref_elem(input logic [NE*DATA_W-1:0] m, input int idx);
        logic [NE*DATA_W-1:0] s;
        s = m >> (DATA_W * idx);
        return s[DATA_W-1:0];
    endfunction

    task automatic test_reset();
        rst       = 1'b0;
        out_ready = 1'b1;
        concatinated_matrix = 72'h090807060504030201;
        for (int i = 0; i < 4; i++) begin
            load = i[0];
            @(negedge clk);
            checks++;
            if ({out_valid, busy, done, out_data, out_row, out_col, out_last} !== '0)
                begin errors++; $display("FAIL reset_hold: outputs=%b required all zero",
                    {out_valid, busy, done, out_data, out_row, out_col, out_last}); end
        end
        load = 1'b0;
        rst  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, busy, done, out_data, out_row, out_col, out_last} !== '0)
                begin errors++; $display("FAIL reset_idle: outputs=%b required all zero",
                    {out_valid, busy, done, out_data, out_row, out_col, out_last}); end
        end
    endtask

    // Streams one matrix. mode 0: ready always high, 1: pattern 1,0,0,1,...,
    // 2: random ready. disturb: corrupt the bus and pulse load mid-stream.
    // Entered and left at a negedge; the load is issued at entry.
    task automatic test_stream(input string name, input logic [NE*DATA_W-1:0] m,
                               input int mode, input bit disturb);
        int   idx;
        int   cyc;
        logic r;
        concatinated_matrix = m;
        load      = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        load = 1'b0;
        idx  = 0;
        cyc  = 0;
        while (idx < NE && cyc < MAXCYC) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
                begin errors++; $display("FAIL %s ctrl cyc%0d: valid=%b busy=%b done=%b required 1 1 0",
                    name, cyc, out_valid, busy, done); end
            checks++;
            if (out_data !== ref_elem(m, idx) || out_row !== 2'(idx / N) ||
                out_col !== 2'(idx % N) || out_last !== (idx == NE - 1))
                begin errors++; $display("FAIL %s elem%0d: data=%h row=%0d col=%0d last=%b required %h %0d %0d %b",
                    name, idx, out_data, out_row, out_col, out_last,
                    ref_elem(m, idx), idx / N, idx % N, idx == NE - 1); end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(1, 0));
            endcase
            if (disturb) begin
                concatinated_matrix = '1;
                load = (cyc == 1) || (cyc == 2);
            end
            out_ready = r;
            if (r) idx++;
            cyc++;
            @(negedge clk);
        end
        load = 1'b0;
        checks++;
        if (cyc >= MAXCYC)
            begin errors++; $display("FAIL %s timeout: transfers=%0d required %0d", name, idx, NE); end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL %s done_cycle: done=%b valid=%b busy=%b required 1 0 1",
                name, done, out_valid, busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL %s idle_after: done=%b valid=%b busy=%b required 0 0 0",
                name, done, out_valid, busy); end
    endtask

    task automatic test_full_stream();
        test_stream("full", 72'h090807060504030201, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        test_stream("backpressure", 72'h090807060504030201, 1, 1'b0);
    endtask

    task automatic test_snapshot_isolation();
        test_stream("snapshot", 72'h090807060504030201, 0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL snapshot_no_recapture: valid=%b busy=%b required 0 0",
                out_valid, busy); end
    endtask

    task automatic test_midstream_reset();
        concatinated_matrix = 72'h090807060504030201;
        load = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_data !== 8'h04)
            begin errors++; $display("FAIL midreset_pre: data=%h required 04", out_data); end
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, done, out_data, out_row, out_col, out_last} !== '0)
            begin errors++; $display("FAIL midreset_async: outputs=%b required all zero",
                {out_valid, busy, done, out_data, out_row, out_col, out_last}); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL midreset_nodone: done=%b valid=%b busy=%b required 0 0 0",
                    done, out_valid, busy); end
        end
        test_stream("after_reset", {NE{8'h11}}, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_stream("b2b_first", 72'h1a2b3c4d5e6f708192, 0, 1'b0);
        test_stream("b2b_second", 72'hc3d4e5f60718293a4b, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [NE*DATA_W-1:0] m;
        for (int k = 0; k < 6; k++) begin
            for (int b = 0; b < NE; b++) m[b*DATA_W +: DATA_W] = 8'($urandom);
            test_stream("random", m, 2, k[0]);
            repeat (k % 3) @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b0;
        load      = 1'b0;
        out_ready = 1'b0;
        concatinated_matrix = '0;
        test_reset();
        test_full_stream();
        test_backpressure();
        test_snapshot_isolation();
        test_midstream_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
